// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - md_op encodings, FSM states and op-class helpers for md_unit
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MADD  = 3'd4;
  localparam logic [2:0] MD_MSUB  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // acc_en folds in whether MADD/MSUB exist in this build
  function automatic logic is_mul_op(input logic [2:0] op, input logic acc_en);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (acc_en && ((op == MD_MADD) || (op == MD_MSUB)));
  endfunction

endpackage

// File: rtl/md_divider.sv
// rtl/md_divider.sv - unsigned iterative restoring divider, one quotient bit per cycle
module md_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (start) begin
        quo <= dividend;
        rem <= '0;
        dvs <= divisor;
        cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        if (cnt == CW'(1)) ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO; MD_MADD_EN adds MADD/MSUB
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
`ifdef MD_MADD_EN
  localparam logic ACC_EN = 1'b1;
`else
  localparam logic ACC_EN = 1'b0;
`endif

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt;
  logic               q_neg_q, r_neg_q, dz_q;

  logic               start_ok, mul_go, div_go;
  logic               sgn_div, rs_neg, rt_neg;
  logic [WIDTH-1:0]   abs_rs, abs_rt;
  logic [2*WIDTH-1:0] prod, mul_res;
  logic [WIDTH-1:0]   div_hi, div_lo;
  logic [WIDTH-1:0]   quo, rem;
  logic               div_ready;

  assign busy = (state != ST_IDLE);

  always_comb begin
    start_ok = (state == ST_IDLE) && start;
    mul_go   = start_ok && is_mul_op(md_op, ACC_EN);
    div_go   = start_ok && is_div_op(md_op);
    sgn_div  = (md_op == MD_DIV);
    rs_neg   = sgn_div && rs[WIDTH-1];
    rt_neg   = sgn_div && rt[WIDTH-1];
    abs_rs   = rs_neg ? -rs : rs;
    abs_rt   = rt_neg ? -rt : rt;
  end

  md_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_go),
    .dividend (abs_rs),
    .divisor  (abs_rt),
    .quo      (quo),
    .rem      (rem),
    .ready    (div_ready)
  );

  always_comb begin
    if (op_q == MD_MULTU)
      prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    else
      prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
`ifdef MD_MADD_EN
    // hi/lo cannot change while busy, so they still hold the start-edge snapshot
    if (op_q == MD_MADD)      mul_res = {hi, lo} + prod;
    else if (op_q == MD_MSUB) mul_res = {hi, lo} - prod;
    else                      mul_res = prod;
`else
    mul_res = prod;
`endif
    div_lo = dz_q ? '1  : (q_neg_q ? -quo : quo);
    div_hi = dz_q ? a_q : (r_neg_q ? -rem : rem);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mul_go) begin
            state <= ST_MUL;
            op_q  <= md_op;
            a_q   <= rs;
            b_q   <= rt;
            cnt   <= CW'(MUL_LAT - 1);
          end else if (div_go) begin
            state   <= ST_DIV;
            op_q    <= md_op;
            a_q     <= rs;
            b_q     <= rt;
            q_neg_q <= rs_neg ^ rt_neg;
            r_neg_q <= rs_neg;
            dz_q    <= (rt == '0);
          end else if (hilo_we && !start) begin
            if (hilo_sel) hi <= rs;
            else          lo <= rs;
          end
        end
        ST_MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= mul_res;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DIV: begin
          if (div_ready) begin
            hi    <= div_hi;
            lo    <= div_lo;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit (WIDTH=32, MUL_LAT=5); honours MD_MADD_EN
module tb_md_unit;

  localparam int W = 32;
  localparam int L = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    md_op = '0;
  logic [W-1:0]  rs = '0, rt = '0;
  logic          hilo_we = 1'b0, hilo_sel = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  md_unit #(.WIDTH(W), .MUL_LAT(L)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .rs(rs), .rt(rt),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return L;
      3'd2, 3'd3: return W + 1;
`ifdef MD_MADD_EN
      3'd4, 3'd5: return L;
`endif
      default: return 0;
    endcase
  endfunction

  // reference: returns {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb;
    int ia, ib;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return acc + 64'(sa * sb);
      3'd5: return acc - 64'(sa * sb);
      default: return acc;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        chk("hilo_result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit mid, input bit we_too);
    logic [63:0] e;
    logic [31:0] oh, ol;
    int lat, n;
    bit bad;
    @(negedge clk);
    oh = m_hi;
    ol = m_lo;
    lat = exp_lat(op);
    start = 1'b1; md_op = op; rs = a; rt = b;
    hilo_we = we_too; hilo_sel = 1'b1;
    if (lat > 0) begin
      e = model(op, a, b, {m_hi, m_lo});
      exp_q.push_back(e);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    n = 0;
    bad = 0;
    @(negedge clk);
    start = 1'b0;
    hilo_we = 1'b0;
    while (busy && n < 100) begin
      n++;
      if (hi !== oh || lo !== ol) bad = 1;
      if (mid && n == 3) begin
        start = 1'b1; md_op = 3'd1; rs = $urandom; rt = $urandom; hilo_we = 1'b1;
      end else begin
        start = 1'b0; hilo_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    hilo_we = 1'b0;
    chk("busy_cycles", 64'(n), 64'(lat));
    chk("hilo_stable_while_busy", {63'b0, bad}, 64'd0);
    @(negedge clk);
    chk("hilo_final", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic do_we(input logic sel, input logic [31:0] v);
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = sel; rs = v; start = 1'b0;
    @(negedge clk);
    hilo_we = 1'b0;
    if (sel) m_hi = v; else m_lo = v;
    chk("hilo_we_write", {hi, lo}, {m_hi, m_lo});
    chk("hilo_we_busy", {63'b0, busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, hi, lo}, 66'd0);
    reset = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    chk("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
    chk("multu_max_x2", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'd3, 32'd7, 32'd0, 0, 0);
    chk("divu_by_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    chk("div_min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);

    do_we(1'b1, 32'h1234);
    do_op(3'd0, 32'd2, 32'd3, 0, 1);
    do_op(3'd7, 32'd5, 32'd5, 0, 1);

    // reset partway through a divide
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; rs = 32'd1000; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_div", {busy, done, hi, lo}, 66'd0);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", {hi, lo}, 64'd0);

`ifdef MD_MADD_EN
    do_we(1'b0, 32'd1);
    do_op(3'd4, 32'd2, 32'd3, 0, 0);
    chk("madd_2x3", {hi, lo}, 64'd7);
    do_op(3'd5, 32'd4, 32'hFFFF_FFFF, 0, 0);
    chk("msub_4xneg1", {hi, lo}, 64'd11);
`else
    do_op(3'd4, 32'd2, 32'd3, 0, 0);
    do_op(3'd5, 32'd2, 32'd3, 0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) do_we(1'($urandom), pick());
      do_op(3'($urandom_range(0, 7)), pick(), pick(),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
